// File: rtl/dot_product_sequencer_pkg.sv
// Shared types and default sizing for the dot-product sequencer slice.
// Derived widths come from helper functions so every file agrees on them.
package dot_seq_pkg;

    localparam int DW_DEF    = 4;
    localparam int AW_DEF    = 9;
    localparam int N_MAX_DEF = 8;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    // The length field must hold N_MAX itself, so it needs one extra code point.
    function automatic int lw_of(input int n_max);
        return $clog2(n_max + 1);
    endfunction

    function automatic int iw_of(input int n_max);
        return $clog2(n_max);
    endfunction

endpackage

// File: rtl/dot_product_sequencer_if.sv
// Host-side register/handshake bundle of the dot-product sequencer.
interface dot_product_sequencer_if #(
    parameter int DW    = dot_seq_pkg::DW_DEF,
    parameter int AW    = dot_seq_pkg::AW_DEF,
    parameter int N_MAX = dot_seq_pkg::N_MAX_DEF
) ();

    localparam int LW = dot_seq_pkg::lw_of(N_MAX);
    localparam int IW = dot_seq_pkg::iw_of(N_MAX);

    logic          wr_en;
    logic [IW-1:0] wr_addr;
    logic [DW-1:0] wr_a;
    logic [DW-1:0] wr_b;
    logic          start;
    logic [LW-1:0] len;
    logic          busy;
    logic          done;
    logic [AW-1:0] result;

    modport master (
        output wr_en, wr_addr, wr_a, wr_b, start, len,
        input  busy, done, result
    );

    modport slave (
        input  wr_en, wr_addr, wr_a, wr_b, start, len,
        output busy, done, result
    );

endinterface

// File: rtl/dot_product_sequencer_operand_store.sv
// Operand vectors A and B packed side by side; synchronous write, combinational read.
module operand_store
    import dot_seq_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int N_MAX = N_MAX_DEF,
    parameter int IW    = iw_of(N_MAX)
) (
    input  logic          clock,
    input  logic          we,
    input  logic [IW-1:0] wr_addr,
    input  logic [DW-1:0] wr_a,
    input  logic [DW-1:0] wr_b,
    input  logic [IW-1:0] rd_addr,
    output logic [DW-1:0] rd_a,
    output logic [DW-1:0] rd_b
);

    logic [2*DW-1:0] mem [N_MAX];

    // Contents are deliberately left unreset; the host reloads them as needed.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[wr_addr] <= {wr_a, wr_b};
        end
    end

    assign {rd_a, rd_b} = mem[rd_addr];

endmodule

// File: rtl/dot_product_sequencer.sv
// Streams stored operand pairs into an external pipelined MAC, clearing it first,
// then waits out the MAC latency and returns the captured dot product.
module dot_product_sequencer
    import dot_seq_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int AW    = AW_DEF,
    parameter int N_MAX = N_MAX_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    dot_product_sequencer_if.slave host,
    output logic                  mac_clr,
    output logic [DW-1:0]         mac_in1,
    output logic [DW-1:0]         mac_in2,
    input  logic [AW-1:0]         mac_out
);

    localparam int LW = lw_of(N_MAX);
    localparam int IW = iw_of(N_MAX);

    state_t        state, state_n;
    logic [LW-1:0] idx, idx_n;
    logic [LW-1:0] len_r, len_n;
    logic          busy_r, busy_n;
    logic          done_r, done_n;
    logic [AW-1:0] result_r, result_n;
    logic          clr_n;
    logic [DW-1:0] in1_n, in2_n;
    logic [DW-1:0] rd_a, rd_b;
    logic          wr_ok;

    assign wr_ok = host.wr_en && (state == IDLE) && (int'(host.wr_addr) < N_MAX);

    operand_store #(
        .DW    (DW),
        .N_MAX (N_MAX),
        .IW    (IW)
    ) u_store (
        .clock   (clock),
        .we      (wr_ok),
        .wr_addr (host.wr_addr),
        .wr_a    (host.wr_a),
        .wr_b    (host.wr_b),
        .rd_addr (idx[IW-1:0]),
        .rd_a    (rd_a),
        .rd_b    (rd_b)
    );

    // Outputs are computed for the next state so they register alongside it.
    // idx doubles as the drain-cycle counter once streaming has finished.
    always_comb begin
        state_n  = state;
        idx_n    = idx;
        len_n    = len_r;
        result_n = result_r;
        done_n   = 1'b0;
        clr_n    = 1'b0;
        in1_n    = '0;
        in2_n    = '0;
        case (state)
            IDLE: begin
                if (host.start) begin
                    state_n = CLEAR;
                    clr_n   = 1'b1;
                    idx_n   = '0;
                    len_n   = (host.len > LW'(N_MAX)) ? LW'(N_MAX) : host.len;
                end
            end
            CLEAR: begin
                if (len_r == '0) begin
                    state_n = DRAIN;
                    idx_n   = '0;
                end else begin
                    state_n = STREAM;
                    in1_n   = rd_a;
                    in2_n   = rd_b;
                    idx_n   = idx + LW'(1);
                end
            end
            STREAM: begin
                if (idx == len_r) begin
                    state_n = DRAIN;
                    idx_n   = '0;
                end else begin
                    in1_n = rd_a;
                    in2_n = rd_b;
                    idx_n = idx + LW'(1);
                end
            end
            DRAIN: begin
                if (idx == '0) begin
                    idx_n = LW'(1);
                end else begin
                    state_n  = DONE;
                    result_n = mac_out;
                    done_n   = 1'b1;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        busy_n = (state_n != IDLE);
    end

    // The MAC is held clear for as long as the sequencer sits in reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            idx      <= '0;
            len_r    <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= '0;
            mac_clr  <= 1'b1;
            mac_in1  <= '0;
            mac_in2  <= '0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            len_r    <= len_n;
            busy_r   <= busy_n;
            done_r   <= done_n;
            result_r <= result_n;
            mac_clr  <= clr_n;
            mac_in1  <= in1_n;
            mac_in2  <= in2_n;
        end
    end

    assign host.busy   = busy_r;
    assign host.done   = done_r;
    assign host.result = result_r;

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Directed bench for dot_product_sequencer with a behavioural two-stage MAC.
module tb_dot_product_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       mac_clr;
    logic [3:0] mac_in1, mac_in2;
    logic [8:0] mac_out;

    int n_checks = 0;
    int n_pass   = 0;

    logic       obs_clr  [0:39];
    logic [3:0] obs_in1  [0:39];
    logic [3:0] obs_in2  [0:39];
    logic       obs_busy [0:39];

    dot_product_sequencer_if #(.DW(4), .AW(9), .N_MAX(8)) host_if ();

    dot_product_sequencer #(.DW(4), .AW(9), .N_MAX(8)) dut (
        .clock   (clock),
        .reset   (reset),
        .host    (host_if),
        .mac_clr (mac_clr),
        .mac_in1 (mac_in1),
        .mac_in2 (mac_in2),
        .mac_out (mac_out)
    );

    always #5 clock = ~clock;

    // Reference MAC: operand in cycle t is visible on mac_out in cycle t+2.
    logic [7:0] prod;
    logic [8:0] acc;
    always @(posedge clock) begin
        if (mac_clr) begin
            prod <= 8'd0;
            acc  <= 9'd0;
        end else begin
            prod <= {4'd0, mac_in1} * {4'd0, mac_in2};
            acc  <= acc + {1'b0, prod};
        end
    end
    assign mac_out = acc;

    task automatic write_elem(input logic [2:0] addr, input logic [3:0] a, input logic [3:0] b);
        host_if.wr_en   = 1'b1;
        host_if.wr_addr = addr;
        host_if.wr_a    = a;
        host_if.wr_b    = b;
        @(posedge clock); #1;
        host_if.wr_en   = 1'b0;
    endtask

    // Issues start in the current cycle (k=0) and records outputs until done.
    task automatic run_job(input logic [3:0] l, output int done_at);
        host_if.start = 1'b1;
        host_if.len   = l;
        @(negedge clock);
        obs_clr[0] = mac_clr; obs_in1[0] = mac_in1; obs_in2[0] = mac_in2; obs_busy[0] = host_if.busy;
        @(posedge clock); #1;
        host_if.start = 1'b0;
        host_if.wr_en = 1'b0;
        done_at = -1;
        for (int k = 1; k < 40 && done_at < 0; k++) begin
            @(negedge clock);
            obs_clr[k] = mac_clr; obs_in1[k] = mac_in1; obs_in2[k] = mac_in2; obs_busy[k] = host_if.busy;
            if (host_if.done) done_at = k;
            @(posedge clock); #1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        @(negedge clock);
        n_checks++;
        if ({host_if.busy, host_if.done, host_if.result, mac_in1, mac_in2, mac_clr} !== {1'b0, 1'b0, 9'd0, 4'd0, 4'd0, 1'b1})
            $display("[TB] FAIL reset_values: busy=%b done=%b result=%0d in1=%0d in2=%0d clr=%b, expected 0 0 0 0 0 1",
                     host_if.busy, host_if.done, host_if.result, mac_in1, mac_in2, mac_clr);
        else n_pass++;
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        n_checks++;
        if (mac_clr !== 1'b1) $display("[TB] FAIL clr_held_after_release: got %b, expected 1", mac_clr);
        else n_pass++;
        @(negedge clock);
        n_checks++;
        if (mac_clr !== 1'b0) $display("[TB] FAIL clr_drops_first_edge: got %b, expected 0", mac_clr);
        else n_pass++;
        @(posedge clock); #1;
    endtask

    task automatic test_basic;
        int d;
        write_elem(3'd0, 4'd1, 4'd4);
        write_elem(3'd1, 4'd2, 4'd5);
        write_elem(3'd2, 4'd3, 4'd6);
        run_job(4'd3, d);
        n_checks++;
        if (d !== 7) $display("[TB] FAIL basic_done_cycle: got %0d, expected 7", d);
        else n_pass++;
        n_checks++;
        if (host_if.result !== 9'd32) $display("[TB] FAIL basic_result: got %0d, expected 32", host_if.result);
        else n_pass++;
        n_checks++;
        if ({obs_in1[2], obs_in2[2], obs_in1[3], obs_in2[3], obs_in1[4], obs_in2[4], obs_in1[5], obs_in2[5]}
            !== {4'd1, 4'd4, 4'd2, 4'd5, 4'd3, 4'd6, 4'd0, 4'd0})
            $display("[TB] FAIL basic_operands: got (%0d,%0d)(%0d,%0d)(%0d,%0d)(%0d,%0d), expected (1,4)(2,5)(3,6)(0,0)",
                     obs_in1[2], obs_in2[2], obs_in1[3], obs_in2[3], obs_in1[4], obs_in2[4], obs_in1[5], obs_in2[5]);
        else n_pass++;
        n_checks++;
        if ({obs_clr[1], obs_clr[2], obs_in1[1], obs_in2[1]} !== {1'b1, 1'b0, 4'd0, 4'd0})
            $display("[TB] FAIL basic_clear_cycle: clr T+1=%b T+2=%b in T+1=(%0d,%0d), expected 1 0 (0,0)",
                     obs_clr[1], obs_clr[2], obs_in1[1], obs_in2[1]);
        else n_pass++;
    endtask

    task automatic test_overflow;
        int d;
        for (int i = 0; i < 8; i++) write_elem(3'(i), 4'd15, 4'd15);
        run_job(4'd8, d);
        n_checks++;
        if (d !== 12 || host_if.result !== 9'd264)
            $display("[TB] FAIL wrap_len8: done=%0d result=%0d, expected done=12 result=264", d, host_if.result);
        else n_pass++;
        run_job(4'd9, d);
        n_checks++;
        if (d !== 12 || host_if.result !== 9'd264)
            $display("[TB] FAIL clamp_len9: done=%0d result=%0d, expected done=12 result=264", d, host_if.result);
        else n_pass++;
    endtask

    task automatic test_zero_len;
        int d;
        int nz;
        run_job(4'd0, d);
        nz = 0;
        for (int k = 1; k <= 4; k++) if (obs_in1[k] !== 4'd0 || obs_in2[k] !== 4'd0) nz++;
        n_checks++;
        if (d !== 4 || host_if.result !== 9'd0)
            $display("[TB] FAIL zero_len_done: done=%0d result=%0d, expected done=4 result=0", d, host_if.result);
        else n_pass++;
        n_checks++;
        if (obs_clr[1] !== 1'b1 || nz !== 0)
            $display("[TB] FAIL zero_len_clr_ops: clr=%b nonzero_ops=%0d, expected clr=1 nonzero_ops=0", obs_clr[1], nz);
        else n_pass++;
    endtask

    task automatic test_busy_protect;
        int d;
        int idle_busy;
        write_elem(3'd0, 4'd1, 4'd1);
        write_elem(3'd1, 4'd2, 4'd1);
        write_elem(3'd2, 4'd3, 4'd1);
        write_elem(3'd3, 4'd4, 4'd1);
        host_if.start = 1'b1; host_if.len = 4'd4;
        @(posedge clock); #1; host_if.start = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        host_if.start = 1'b1; host_if.len = 4'd1;
        host_if.wr_en = 1'b1; host_if.wr_addr = 3'd0; host_if.wr_a = 4'd9; host_if.wr_b = 4'd9;
        @(posedge clock); #1;
        host_if.start = 1'b0; host_if.wr_en = 1'b0;
        d = -1;
        for (int k = 4; k < 40 && d < 0; k++) begin
            @(negedge clock);
            if (host_if.done) d = k;
            @(posedge clock); #1;
        end
        n_checks++;
        if (d !== 8 || host_if.result !== 9'd10)
            $display("[TB] FAIL busy_run: done=%0d result=%0d, expected done=8 result=10", d, host_if.result);
        else n_pass++;
        idle_busy = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            if (host_if.busy !== 1'b0) idle_busy++;
            @(posedge clock); #1;
        end
        n_checks++;
        if (idle_busy !== 0) $display("[TB] FAIL busy_no_queue: busy cycles=%0d, expected 0", idle_busy);
        else n_pass++;
        run_job(4'd4, d);
        n_checks++;
        if (host_if.result !== 9'd10) $display("[TB] FAIL busy_write_dropped: got %0d, expected 10", host_if.result);
        else n_pass++;
    endtask

    task automatic test_reset_mid_run;
        int d;
        host_if.start = 1'b1; host_if.len = 4'd4;
        @(posedge clock); #1; host_if.start = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({host_if.busy, host_if.done, host_if.result, mac_in1, mac_in2, mac_clr} !== {1'b0, 1'b0, 9'd0, 4'd0, 4'd0, 1'b1})
            $display("[TB] FAIL midrun_reset: busy=%b done=%b result=%0d in1=%0d in2=%0d clr=%b, expected 0 0 0 0 0 1",
                     host_if.busy, host_if.done, host_if.result, mac_in1, mac_in2, mac_clr);
        else n_pass++;
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        write_elem(3'd0, 4'd7, 4'd3);
        write_elem(3'd1, 4'd7, 4'd1);
        run_job(4'd2, d);
        n_checks++;
        if (d !== 6 || host_if.result !== 9'd28)
            $display("[TB] FAIL post_reset_run: done=%0d result=%0d, expected done=6 result=28", d, host_if.result);
        else n_pass++;
    endtask

    task automatic test_simultaneous;
        int d;
        host_if.wr_en = 1'b1; host_if.wr_addr = 3'd0; host_if.wr_a = 4'd5; host_if.wr_b = 4'd5;
        run_job(4'd1, d);
        n_checks++;
        if (host_if.result !== 9'd25) $display("[TB] FAIL start_with_write: got %0d, expected 25", host_if.result);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        int d1;
        int d2;
        int lows;
        run_job(4'd2, d1);
        lows = 0;
        for (int k = 1; k <= d1 && k < 40; k++) if (obs_busy[k] !== 1'b1) lows++;
        n_checks++;
        if (d1 !== 6 || host_if.result !== 9'd32 || lows !== 0)
            $display("[TB] FAIL b2b_first: done=%0d result=%0d busy_gaps=%0d, expected 6 32 0", d1, host_if.result, lows);
        else n_pass++;
        run_job(4'd1, d2);
        n_checks++;
        if (obs_busy[0] !== 1'b0 || obs_busy[1] !== 1'b1 || obs_clr[1] !== 1'b1)
            $display("[TB] FAIL b2b_gap: busy idle=%b busy T+1=%b clr T+1=%b, expected 0 1 1", obs_busy[0], obs_busy[1], obs_clr[1]);
        else n_pass++;
        n_checks++;
        if (d2 !== 5 || host_if.result !== 9'd25)
            $display("[TB] FAIL b2b_second: done=%0d result=%0d, expected done=5 result=25", d2, host_if.result);
        else n_pass++;
        repeat (3) begin @(posedge clock); #1; end
        n_checks++;
        if (host_if.result !== 9'd25) $display("[TB] FAIL result_hold: got %0d, expected 25", host_if.result);
        else n_pass++;
    endtask

    initial begin
        host_if.wr_en = 1'b0; host_if.wr_addr = '0; host_if.wr_a = '0; host_if.wr_b = '0;
        host_if.start = 1'b0; host_if.len = '0;
        test_reset();
        test_basic();
        test_overflow();
        test_zero_len();
        test_busy_protect();
        test_reset_mid_run();
        test_simultaneous();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
